// File: rtl/l2_req_out_tx_pkg.sv
// Shared cache types for the L2 request-out path: message codes,
// field types and the queued request entry.
package l2_req_out_tx_pkg;

  typedef enum logic [1:0] {
    REQ_GETS = 2'd0,
    REQ_GETM = 2'd1,
    REQ_PUTS = 2'd2,
    REQ_PUTM = 2'd3
  } mix_msg_t;

  typedef logic [1:0]   hprot_t;
  typedef logic [27:0]  line_addr_t;
  typedef logic [127:0] line_t;

  typedef struct packed {
    mix_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
  } req_out_entry_t;

endpackage

// File: rtl/l2_req_out_fifo.sv
// Circular request queue: entry storage, wrapping pointers, occupancy.
// Ports: clk, rst, push/din, pop/dout (head entry), count.
module l2_req_out_fifo
  import l2_req_out_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  req_out_entry_t             din,
  input  logic                       pop,
  output req_out_entry_t             dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_out_entry_t mem_q [DEPTH];
  req_out_entry_t mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only occupied slots are ever read out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/l2_req_out_tx.sv
// L2 request-out queue toward the LLC with PutM flow control: PutMs in
// flight (sent, awaiting FWD_PUTACK) plus queued PutMs are capped at
// MAX_PUTM. Optional macro L2_REQ_OUT_BYPASS_EN adds empty-queue bypass.
// Ports: push_* (in handshake), l2_req_out_* (out handshake),
// putack_in, count, putm_pending, putack_underflow (sticky).
module l2_req_out_tx
  import l2_req_out_tx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_PUTM = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  mix_msg_t                      push_coh_msg,
  input  hprot_t                        push_hprot,
  input  line_addr_t                    push_addr,
  input  line_t                         push_line,
  output logic                          l2_req_out_valid,
  input  logic                          l2_req_out_ready,
  output mix_msg_t                      l2_req_out_coh_msg,
  output hprot_t                        l2_req_out_hprot,
  output line_addr_t                    l2_req_out_addr,
  output line_t                         l2_req_out_line,
  input  logic                          putack_in,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(MAX_PUTM):0]     putm_pending,
  output logic                          putack_underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(MAX_PUTM) + 1;

  req_out_entry_t push_ent;
  req_out_entry_t head_ent;
  req_out_entry_t out_ent;
  logic [CW-1:0]  fcount;
  logic           empty;
  logic           putm_block;
  logic           push_fire;
  logic           pop;
  logic           q_push;
  logic           q_pop;
  logic           pend_inc;

  logic [CW-1:0]  queued_putm_q, queued_putm_d;
  logic [PW-1:0]  putm_pending_q, putm_pending_d;
  logic           underflow_q, underflow_d;

  assign push_ent = '{
    coh_msg: push_coh_msg,
    hprot:   push_hprot,
    addr:    push_addr,
    line:    push_line
  };

  assign empty = (fcount == '0);

  // Reserve PutM credits for queued PutMs too, so every queued PutM
  // is guaranteed a slot once it reaches the head.
  assign putm_block = (push_coh_msg == REQ_PUTM) &&
    ((int'(putm_pending_q) + int'(queued_putm_q)) >= MAX_PUTM);

  // Readiness depends only on occupancy, never on a same-cycle pop.
  assign push_ready = (int'(fcount) < DEPTH) && !putm_block;
  assign push_fire  = push_valid && push_ready;

`ifdef L2_REQ_OUT_BYPASS_EN
  logic byp;
  assign byp              = empty && push_fire;
  assign l2_req_out_valid = !empty || byp;
  assign out_ent          = byp ? push_ent : head_ent;
  assign q_push           = push_fire && !(byp && l2_req_out_ready);
`else
  assign l2_req_out_valid = !empty;
  assign out_ent          = head_ent;
  assign q_push           = push_fire;
`endif

  assign pop      = l2_req_out_valid && l2_req_out_ready;
  assign q_pop    = pop && !empty;
  assign pend_inc = pop && (out_ent.coh_msg == REQ_PUTM);

  l2_req_out_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (q_push),
    .din  (push_ent),
    .pop  (q_pop),
    .dout (head_ent),
    .count(fcount)
  );

  always_comb begin
    queued_putm_d  = queued_putm_q;
    putm_pending_d = putm_pending_q;
    underflow_d    = underflow_q;
    if ((q_push && push_coh_msg == REQ_PUTM) &&
        !(q_pop && head_ent.coh_msg == REQ_PUTM)) begin
      queued_putm_d = queued_putm_q + CW'(1);
    end else if (!(q_push && push_coh_msg == REQ_PUTM) &&
                 (q_pop && head_ent.coh_msg == REQ_PUTM)) begin
      queued_putm_d = queued_putm_q - CW'(1);
    end
    if (pend_inc && !putack_in) begin
      putm_pending_d = putm_pending_q + PW'(1);
    end else if (!pend_inc && putack_in) begin
      if (putm_pending_q == '0) begin
        underflow_d = 1'b1;
      end else begin
        putm_pending_d = putm_pending_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      queued_putm_q  <= '0;
      putm_pending_q <= '0;
      underflow_q    <= 1'b0;
    end else begin
      queued_putm_q  <= queued_putm_d;
      putm_pending_q <= putm_pending_d;
      underflow_q    <= underflow_d;
    end
  end

  assign l2_req_out_coh_msg = out_ent.coh_msg;
  assign l2_req_out_hprot   = out_ent.hprot;
  assign l2_req_out_addr    = out_ent.addr;
  assign l2_req_out_line    = out_ent.line;
  assign count              = fcount;
  assign putm_pending       = putm_pending_q;
  assign putack_underflow   = underflow_q;

endmodule

// File: tb/tb_l2_req_out_tx.sv
// Self-checking bench for l2_req_out_tx against a queue-based model.
// Directed scenarios plus a randomized run.
module tb_l2_req_out_tx;
  import l2_req_out_tx_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_PUTM = 2;
`ifdef L2_REQ_OUT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic       push_ready;
  mix_msg_t   push_coh_msg;
  hprot_t     push_hprot;
  line_addr_t push_addr;
  line_t      push_line;
  logic       l2_req_out_valid;
  logic       l2_req_out_ready;
  mix_msg_t   l2_req_out_coh_msg;
  hprot_t     l2_req_out_hprot;
  line_addr_t l2_req_out_addr;
  line_t      l2_req_out_line;
  logic       putack_in;
  logic [$clog2(DEPTH):0]    count;
  logic [$clog2(MAX_PUTM):0] putm_pending;
  logic       putack_underflow;

  int nvec = 0;
  int nerr = 0;

  req_out_entry_t mq[$];
  int m_pend = 0;
  bit m_uf   = 1'b0;

  always #5 clk = ~clk;

  l2_req_out_tx #(
    .DEPTH   (DEPTH),
    .MAX_PUTM(MAX_PUTM)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_coh_msg      (push_coh_msg),
    .push_hprot        (push_hprot),
    .push_addr         (push_addr),
    .push_line         (push_line),
    .l2_req_out_valid  (l2_req_out_valid),
    .l2_req_out_ready  (l2_req_out_ready),
    .l2_req_out_coh_msg(l2_req_out_coh_msg),
    .l2_req_out_hprot  (l2_req_out_hprot),
    .l2_req_out_addr   (l2_req_out_addr),
    .l2_req_out_line   (l2_req_out_line),
    .putack_in         (putack_in),
    .count             (count),
    .putm_pending      (putm_pending),
    .putack_underflow  (putack_underflow)
  );

  function automatic req_out_entry_t cur_push();
    req_out_entry_t e;
    e.coh_msg = push_coh_msg;
    e.hprot   = push_hprot;
    e.addr    = push_addr;
    e.line    = push_line;
    return e;
  endfunction

  function automatic bit m_ready();
    int qp = 0;
    foreach (mq[i]) if (mq[i].coh_msg == REQ_PUTM) qp++;
    return (mq.size() < DEPTH) &&
      !(push_coh_msg == REQ_PUTM && m_pend + qp >= MAX_PUTM);
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0) || (BYP && push_valid && m_ready());
  endfunction

  function automatic req_out_entry_t m_head();
    return (mq.size() != 0) ? mq[0] : cur_push();
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    bit pf, pp, inc;
    req_out_entry_t e, h;
    pf = push_valid && m_ready();
    pp = m_valid() && l2_req_out_ready;
    h  = m_head();
    e  = cur_push();
    inc = pp && (h.coh_msg == REQ_PUTM);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pend = 0;
      m_uf   = 1'b0;
    end else begin
      if (BYP && mq.size() == 0 && pf) begin
        if (!pp) mq.push_back(e);
      end else begin
        if (pp) void'(mq.pop_front());
        if (pf) mq.push_back(e);
      end
      if (inc && !putack_in) m_pend++;
      else if (!inc && putack_in) begin
        if (m_pend == 0) m_uf = 1'b1;
        else m_pend--;
      end
    end
    #1;
  endtask

  task automatic set_push(bit v, mix_msg_t m, logic [27:0] a);
    push_valid   = v;
    push_coh_msg = m;
    push_addr    = a;
    push_hprot   = hprot_t'($urandom_range(0, 3));
    push_line    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    l2_req_out_ready = 1'b0;
    putack_in = 1'b0;
    set_push(1'b0, REQ_GETS, 28'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    nvec++;
    if (l2_req_out_valid !== 1'b0 || count !== '0) begin
      $display("FAIL reset_out: valid=%b count=%0d want 0/0",
               l2_req_out_valid, count);
      nerr++;
    end
    nvec++;
    if (push_ready !== 1'b1 || putm_pending !== '0 ||
        putack_underflow !== 1'b0) begin
      $display("FAIL reset_flags: ready=%b pend=%0d uf=%b want 1/0/0",
               push_ready, putm_pending, putack_underflow);
      nerr++;
    end
  endtask

  task automatic test_single();
    l2_req_out_ready = 1'b1;
    set_push(1'b1, REQ_GETS, 28'h100);
    step();
    set_push(1'b0, REQ_GETS, 28'h0);
    #1;
    nvec++;
    if (l2_req_out_valid !== m_valid()) begin
      $display("FAIL single_valid: got %b want %b",
               l2_req_out_valid, m_valid());
      nerr++;
    end
    if (!BYP) begin
      nvec++;
      if (l2_req_out_addr !== 28'h100) begin
        $display("FAIL single_addr: got %h want 100", l2_req_out_addr);
        nerr++;
      end
    end
    step();
    nvec++;
    if (count !== '0 || l2_req_out_valid !== 1'b0) begin
      $display("FAIL single_drain: count=%0d valid=%b want 0/0",
               count, l2_req_out_valid);
      nerr++;
    end
  endtask

  task automatic test_fill();
    l2_req_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, REQ_GETM, 28'h10 + 28'(i));
      #1;
      nvec++;
      if (push_ready !== 1'b1) begin
        $display("FAIL fill_ready%0d: got %b want 1", i, push_ready);
        nerr++;
      end
      step();
    end
    l2_req_out_ready = 1'b1;
    #1;
    nvec++;
    if (int'(count) !== DEPTH || push_ready !== 1'b0) begin
      $display("FAIL fill_full: count=%0d ready=%b want %0d/0",
               count, push_ready, DEPTH);
      nerr++;
    end
    set_push(1'b0, REQ_GETS, 28'h0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      nvec++;
      if (l2_req_out_valid !== 1'b1 ||
          l2_req_out_addr !== 28'h10 + 28'(i)) begin
        $display("FAIL fill_order%0d: valid=%b addr=%h want 1/%h",
                 i, l2_req_out_valid, l2_req_out_addr, 28'h10 + 28'(i));
        nerr++;
      end
      step();
    end
    nvec++;
    if (count !== '0) begin
      $display("FAIL fill_empty: count=%0d want 0", count);
      nerr++;
    end
  endtask

  task automatic test_putm_limit();
    int acc = 0;
    l2_req_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_push(1'b1, REQ_PUTM, 28'h40 + 28'(acc));
      #1;
      nvec++;
      if (push_ready !== m_ready()) begin
        $display("FAIL putm_ready%0d: got %b want %b",
                 c, push_ready, m_ready());
        nerr++;
      end
      if (m_ready()) acc++;
      step();
    end
    #1;
    nvec++;
    if (acc !== 2 || int'(putm_pending) !== 2 || push_ready !== 1'b0) begin
      $display("FAIL putm_stall: acc=%0d pend=%0d ready=%b want 2/2/0",
               acc, putm_pending, push_ready);
      nerr++;
    end
    push_coh_msg = REQ_GETS;
    #1;
    nvec++;
    if (push_ready !== 1'b1) begin
      $display("FAIL putm_gets_free: got %b want 1", push_ready);
      nerr++;
    end
    push_valid = 1'b0;
    push_coh_msg = REQ_PUTM;
    putack_in = 1'b1;
    step();
    putack_in = 1'b0;
    push_valid = 1'b1;
    #1;
    nvec++;
    if (int'(putm_pending) !== 1 || push_ready !== 1'b1) begin
      $display("FAIL putm_release: pend=%0d ready=%b want 1/1",
               putm_pending, push_ready);
      nerr++;
    end
    step();
    push_valid = 1'b0;
    step();
    step();
    putack_in = 1'b1;
    step();
    step();
    putack_in = 1'b0;
    #1;
    nvec++;
    if (putm_pending !== '0 || count !== '0) begin
      $display("FAIL putm_drain: pend=%0d count=%0d want 0/0",
               putm_pending, count);
      nerr++;
    end
  endtask

  task automatic test_same_cycle();
    l2_req_out_ready = 1'b0;
    set_push(1'b1, REQ_PUTM, 28'h80);
    step();
    set_push(1'b1, REQ_PUTM, 28'h81);
    step();
    push_valid = 1'b0;
    l2_req_out_ready = 1'b1;
    step();
    nvec++;
    if (int'(putm_pending) !== 1) begin
      $display("FAIL same_pre: pend=%0d want 1", putm_pending);
      nerr++;
    end
    putack_in = 1'b1;
    step();
    putack_in = 1'b0;
    #1;
    nvec++;
    if (int'(putm_pending) !== 1 || count !== '0) begin
      $display("FAIL same_cycle: pend=%0d count=%0d want 1/0",
               putm_pending, count);
      nerr++;
    end
  endtask

  task automatic test_underflow();
    putack_in = 1'b1;
    step();
    putack_in = 1'b0;
    #1;
    nvec++;
    if (putm_pending !== '0 || putack_underflow !== 1'b0) begin
      $display("FAIL uf_pre: pend=%0d uf=%b want 0/0",
               putm_pending, putack_underflow);
      nerr++;
    end
    putack_in = 1'b1;
    step();
    putack_in = 1'b0;
    l2_req_out_ready = 1'b0;
    set_push(1'b1, REQ_GETS, 28'h90);
    step();
    push_valid = 1'b0;
    step();
    step();
    nvec++;
    if (putack_underflow !== 1'b1 || putm_pending !== '0 ||
        count !== 1) begin
      $display("FAIL uf_sticky: uf=%b pend=%0d count=%0d want 1/0/1",
               putack_underflow, putm_pending, count);
      nerr++;
    end
    rst = 1'b1;
    step();
    nvec++;
    if (putack_underflow !== 1'b0 || count !== '0 ||
        l2_req_out_valid !== 1'b0) begin
      $display("FAIL uf_reset: uf=%b count=%0d valid=%b want 0/0/0",
               putack_underflow, count, l2_req_out_valid);
      nerr++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_bypass();
`ifdef L2_REQ_OUT_BYPASS_EN
    l2_req_out_ready = 1'b1;
    set_push(1'b1, REQ_GETS, 28'h200);
    #1;
    nvec++;
    if (l2_req_out_valid !== 1'b1 || l2_req_out_addr !== 28'h200) begin
      $display("FAIL bypass_same: valid=%b addr=%h want 1/200",
               l2_req_out_valid, l2_req_out_addr);
      nerr++;
    end
    step();
    push_valid = 1'b0;
    #1;
    nvec++;
    if (count !== '0 || l2_req_out_valid !== 1'b0) begin
      $display("FAIL bypass_count: count=%0d valid=%b want 0/0",
               count, l2_req_out_valid);
      nerr++;
    end
`endif
  endtask

  task automatic test_random();
    req_out_entry_t h;
    for (int c = 0; c < 400; c++) begin
      set_push($urandom_range(0, 2) != 0,
               mix_msg_t'($urandom_range(0, 3)),
               28'($urandom));
      l2_req_out_ready = ($urandom_range(0, 2) == 0);
      putack_in = (m_pend > 0) && ($urandom_range(0, 3) == 0);
      #1;
      nvec++;
      if (push_ready !== m_ready() || l2_req_out_valid !== m_valid()) begin
        $display("FAIL rnd_hs%0d: ready=%b valid=%b want %b/%b",
                 c, push_ready, l2_req_out_valid, m_ready(), m_valid());
        nerr++;
      end
      if (m_valid()) begin
        h = m_head();
        nvec++;
        if (l2_req_out_coh_msg !== h.coh_msg ||
            l2_req_out_addr !== h.addr ||
            l2_req_out_hprot !== h.hprot ||
            l2_req_out_line !== h.line) begin
          $display("FAIL rnd_head%0d: msg=%0d addr=%h want %0d/%h",
                   c, l2_req_out_coh_msg, l2_req_out_addr,
                   h.coh_msg, h.addr);
          nerr++;
        end
      end
      nvec++;
      if (int'(count) !== mq.size() || int'(putm_pending) !== m_pend ||
          putack_underflow !== m_uf) begin
        $display("FAIL rnd_state%0d: count=%0d pend=%0d uf=%b want %0d/%0d/%b",
                 c, count, putm_pending, putack_underflow,
                 mq.size(), m_pend, m_uf);
        nerr++;
      end
      step();
    end
    push_valid = 1'b0;
    putack_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_putm_limit();
    test_same_cycle();
    test_underflow();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
